// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: Moore FSM driving the datapath, with a Mealy branch enable,
// a retired-instruction counter and a one-cycle illegal-instruction pulse.
module mc_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Function,
    input  logic             Zero,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic             PCSel,
    output logic             Jr,
    output logic             Jal,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUCtrl,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_RWB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_ADDIEX, S_ADDIWB
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       memto_reg;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic       pc_sel;
        logic       jr;
        logic       jal;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       illegal;
    } ctl_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t           state;
    state_t           next_state;
    ctl_t             ctl;
    ctl_t             ctl_out;
    logic [CNT_W-1:0] instr_cnt;
    logic             retire;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= S_FETCH;
            instr_cnt <= '0;
        end else begin
            state <= next_state;
            if (retire)
                instr_cnt <= instr_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        ctl        = '0;
        case (state)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.ir_write  = 1'b1;
                ctl.alu_src_b = 2'b01;
                ctl.alu_ctrl  = ALU_ADD;
                ctl.pc_sel    = 1'b1;
                next_state    = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut here.
                ctl.alu_src_b = 2'b11;
                ctl.alu_ctrl  = ALU_ADD;
                case (OpCode)
                    6'h23, 6'h2B: next_state = S_MEMADR;
                    6'h00: begin
                        case (Function)
                            6'h08:                             next_state = S_JR;
                            6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: next_state = S_EXEC;
                            default: begin
                                ctl.illegal = 1'b1;
                                next_state  = S_FETCH;
                            end
                        endcase
                    end
                    6'h04, 6'h05: next_state = S_BRANCH;
                    6'h02:        next_state = S_JUMP;
                    6'h03:        next_state = S_JAL;
                    6'h08:        next_state = S_ADDIEX;
                    default: begin
                        ctl.illegal = 1'b1;
                        next_state  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                ctl.alu_ctrl  = ALU_ADD;
                next_state    = (OpCode == 6'h23) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctl.iord     = 1'b1;
                ctl.mem_read = 1'b1;
                next_state   = S_MEMWB;
            end
            S_MEMWB: begin
                ctl.reg_write = 1'b1;
                ctl.memto_reg = 1'b1;
                next_state    = S_FETCH;
            end
            S_MEMWR: begin
                ctl.iord      = 1'b1;
                ctl.mem_write = 1'b1;
                next_state    = S_FETCH;
            end
            S_EXEC: begin
                ctl.alu_src_a = 1'b1;
                case (Function)
                    6'h22:   ctl.alu_ctrl = ALU_SUB;
                    6'h24:   ctl.alu_ctrl = ALU_AND;
                    6'h25:   ctl.alu_ctrl = ALU_OR;
                    6'h2A:   ctl.alu_ctrl = ALU_SLT;
                    default: ctl.alu_ctrl = ALU_ADD;
                endcase
                next_state = S_RWB;
            end
            S_RWB: begin
                ctl.reg_dst   = 1'b1;
                ctl.reg_write = 1'b1;
                next_state    = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_ctrl  = ALU_SUB;
                ctl.pc_source = 2'b01;
                // Mealy: PC write follows the live zero flag of the compare.
                ctl.pc_sel    = (OpCode == 6'h05) ? ~Zero : Zero;
                next_state    = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_sel    = 1'b1;
                ctl.pc_source = 2'b10;
                next_state    = S_FETCH;
            end
            S_JAL: begin
                ctl.pc_sel    = 1'b1;
                ctl.pc_source = 2'b10;
                ctl.reg_write = 1'b1;
                ctl.jal       = 1'b1;
                next_state    = S_FETCH;
            end
            S_JR: begin
                ctl.jr     = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                ctl.alu_ctrl  = ALU_ADD;
                next_state    = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctl.reg_write = 1'b1;
                next_state    = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    assign retire = (state != S_FETCH) && (next_state == S_FETCH) && !ctl.illegal;

    // Reset forces every control low in the same cycle so an aborted instruction writes nothing.
    assign ctl_out    = Rst ? '0 : ctl;
    assign InstrCount = Rst ? '0 : instr_cnt;

    assign IorD     = ctl_out.iord;
    assign MemRead  = ctl_out.mem_read;
    assign MemWrite = ctl_out.mem_write;
    assign MemtoReg = ctl_out.memto_reg;
    assign IRWrite  = ctl_out.ir_write;
    assign RegDst   = ctl_out.reg_dst;
    assign RegWrite = ctl_out.reg_write;
    assign ALUSrcA  = ctl_out.alu_src_a;
    assign PCSel    = ctl_out.pc_sel;
    assign Jr       = ctl_out.jr;
    assign Jal      = ctl_out.jal;
    assign PCSource = ctl_out.pc_source;
    assign ALUSrcB  = ctl_out.alu_src_b;
    assign ALUCtrl  = ctl_out.alu_ctrl;
    assign Illegal  = ctl_out.illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: expected per-cycle control words are queued per instruction
// and popped against the DUT outputs each cycle; a 4-bit counter instance exercises wrap.
module tb_mc_control_fsm;
    localparam int CW = 4;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic [5:0]    OpCode = 6'h00;
    logic [5:0]    Function = 6'h00;
    logic          Zero = 1'b0;
    logic          IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA;
    logic          PCSel, Jr, Jal, Illegal;
    logic [1:0]    PCSource, ALUSrcB;
    logic [2:0]    ALUCtrl;
    logic [CW-1:0] InstrCount;

    mc_control_fsm #(.CNT_W(CW)) dut (
        .Clk(Clk), .Rst(Rst), .OpCode(OpCode), .Function(Function), .Zero(Zero),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .PCSel(PCSel), .Jr(Jr), .Jal(Jal), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUCtrl(ALUCtrl), .Illegal(Illegal), .InstrCount(InstrCount)
    );

    always #5 Clk = ~Clk;

    // {Illegal, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA, PCSel, Jr, Jal,
    //  PCSource[1:0], ALUSrcB[1:0], ALUCtrl[2:0]}
    wire [18:0] obs = {Illegal, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite,
                       ALUSrcA, PCSel, Jr, Jal, PCSource, ALUSrcB, ALUCtrl};

    localparam logic [18:0] ILL = 19'h1 << 18, IORD = 19'h1 << 17, MRD = 19'h1 << 16;
    localparam logic [18:0] MWR = 19'h1 << 15, M2R = 19'h1 << 14, IRW = 19'h1 << 13;
    localparam logic [18:0] RDST = 19'h1 << 12, RW = 19'h1 << 11, SRCA = 19'h1 << 10;
    localparam logic [18:0] PCS = 19'h1 << 9, JRB = 19'h1 << 8, JALB = 19'h1 << 7;
    localparam logic [18:0] PS01 = 19'h1 << 5, PS10 = 19'h2 << 5;
    localparam logic [18:0] SB01 = 19'h1 << 3, SB10 = 19'h2 << 3, SB11 = 19'h3 << 3;
    localparam logic [18:0] A_AND = 19'h0, A_OR = 19'h1, A_ADD = 19'h2, A_SUB = 19'h6, A_SLT = 19'h7;
    localparam logic [18:0] W_FETCH = MRD | IRW | SB01 | A_ADD | PCS;
    localparam logic [18:0] W_DECODE = SB11 | A_ADD;

    int            vectors = 0;
    int            miscompares = 0;
    logic [18:0]   exp_q[$];
    logic [CW-1:0] exp_cnt = '0;

    // Pushes the full expected control sequence of one instruction; returns whether it retires.
    function automatic logic push_seq(input logic [5:0] op, input logic [5:0] fn, input logic z);
        logic legal;
        legal = 1'b1;
        exp_q.push_back(W_FETCH);
        case (op)
            6'h23: begin
                exp_q.push_back(W_DECODE);
                exp_q.push_back(SRCA | SB10 | A_ADD);
                exp_q.push_back(IORD | MRD);
                exp_q.push_back(RW | M2R);
            end
            6'h2B: begin
                exp_q.push_back(W_DECODE);
                exp_q.push_back(SRCA | SB10 | A_ADD);
                exp_q.push_back(IORD | MWR);
            end
            6'h04, 6'h05: begin
                exp_q.push_back(W_DECODE);
                exp_q.push_back(SRCA | A_SUB | PS01 | (((op == 6'h04) ? z : !z) ? PCS : 19'h0));
            end
            6'h02: begin
                exp_q.push_back(W_DECODE);
                exp_q.push_back(PCS | PS10);
            end
            6'h03: begin
                exp_q.push_back(W_DECODE);
                exp_q.push_back(PCS | PS10 | RW | JALB);
            end
            6'h08: begin
                exp_q.push_back(W_DECODE);
                exp_q.push_back(SRCA | SB10 | A_ADD);
                exp_q.push_back(RW);
            end
            6'h00: begin
                case (fn)
                    6'h08: begin
                        exp_q.push_back(W_DECODE);
                        exp_q.push_back(JRB);
                    end
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: begin
                        exp_q.push_back(W_DECODE);
                        exp_q.push_back(SRCA | ((fn == 6'h20) ? A_ADD : (fn == 6'h22) ? A_SUB :
                                        (fn == 6'h24) ? A_AND : (fn == 6'h25) ? A_OR : A_SLT));
                        exp_q.push_back(RDST | RW);
                    end
                    default: begin
                        exp_q.push_back(W_DECODE | ILL);
                        legal = 1'b0;
                    end
                endcase
            end
            default: begin
                exp_q.push_back(W_DECODE | ILL);
                legal = 1'b0;
            end
        endcase
        return legal;
    endfunction

    // Runs one instruction from FETCH; stop_after>0 abandons it after that many cycles.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int stop_after, input string name);
        logic [18:0] e;
        logic        legal;
        int          n;
        n = 0;
        OpCode = op;
        Function = fn;
        Zero = z;
        legal = push_seq(op, fn, z);
        while (exp_q.size() > 0 && (stop_after == 0 || n < stop_after)) begin
            e = exp_q.pop_front();
            @(negedge Clk);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL %s cycle %0d: ctl got %h expected %h", name, n, obs, e);
            end
            vectors++;
            if ((PCSel && Jr) || (MemRead && MemWrite)) begin
                miscompares++;
                $display("FAIL %s cycle %0d exclusivity: PCSel=%b Jr=%b MemRead=%b MemWrite=%b",
                         name, n, PCSel, Jr, MemRead, MemWrite);
            end
            n++;
            @(posedge Clk);
            #1;
        end
        if (stop_after == 0) begin
            if (legal) exp_cnt = exp_cnt + 1'b1;
            vectors++;
            if (InstrCount !== exp_cnt) begin
                miscompares++;
                $display("FAIL %s InstrCount: got %0d expected %0d", name, InstrCount, exp_cnt);
            end
        end else begin
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge Clk);
        vectors++;
        if (obs !== 19'h0 || InstrCount !== '0) begin
            miscompares++;
            $display("FAIL %s: ctl got %h cnt %0d, expected all zero", name, obs, InstrCount);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        OpCode = 6'h23;
        check_reset_outputs("reset_c0");
        check_reset_outputs("reset_c1");
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_mem();
        run_instr(6'h23, 6'h00, 1'b0, 0, "lw");
        run_instr(6'h2B, 6'h00, 1'b0, 0, "sw");
    endtask

    task automatic test_rtype();
        run_instr(6'h00, 6'h22, 1'b0, 0, "sub");
        run_instr(6'h00, 6'h2A, 1'b0, 0, "slt");
        run_instr(6'h00, 6'h20, 1'b1, 0, "add");
        run_instr(6'h00, 6'h24, 1'b0, 0, "and");
        run_instr(6'h00, 6'h25, 1'b0, 0, "or");
        run_instr(6'h08, 6'h3F, 1'b0, 0, "addi");
    endtask

    task automatic test_branch();
        run_instr(6'h04, 6'h00, 1'b1, 0, "beq_taken");
        run_instr(6'h04, 6'h00, 1'b0, 0, "beq_not_taken");
        run_instr(6'h05, 6'h00, 1'b0, 0, "bne_taken");
        run_instr(6'h05, 6'h00, 1'b1, 0, "bne_not_taken");
    endtask

    task automatic test_jumps();
        run_instr(6'h02, 6'h00, 1'b0, 0, "j");
        run_instr(6'h03, 6'h00, 1'b0, 0, "jal");
        run_instr(6'h00, 6'h08, 1'b1, 0, "jr");
    endtask

    task automatic test_illegal();
        run_instr(6'h3F, 6'h00, 1'b0, 0, "illegal_op");
        run_instr(6'h00, 6'h3F, 1'b0, 0, "illegal_funct");
        run_instr(6'h2B, 6'h00, 1'b0, 0, "sw_after_illegal");
    endtask

    task automatic test_reset_mid();
        run_instr(6'h23, 6'h00, 1'b0, 3, "lw_abort");
        Rst = 1'b1;
        check_reset_outputs("reset_in_memrd");
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        exp_cnt = '0;
        run_instr(6'h00, 6'h20, 1'b0, 0, "add_after_abort");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 17; i++)
            run_instr(6'h02, 6'h00, 1'b0, 0, "j_wrap");
    endtask

    initial begin
        test_reset();
        test_mem();
        test_rtype();
        test_branch();
        test_jumps();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
